// File: rtl/gcd_job_driver.sv
// Requester-side front end for the subtractive GCD engine: operand stream in, result stream out.
// Optional watchdog abort of hung jobs is enabled with `define GCD_DRV_WATCHDOG_EN.
module gcd_job_driver #(
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TO_W           = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_err,
  output logic [WIDTH-1:0] eng_a,
  output logic [WIDTH-1:0] eng_b,
  output logic             eng_start,
  input  logic             eng_done,
  input  logic [WIDTH-1:0] eng_result,
  output logic             eng_rst,
  output logic             busy
);

  if (TIMEOUT_CYCLES > (2**TO_W) - 1) begin : g_cfg_check
    $error("gcd_job_driver: TIMEOUT_CYCLES does not fit in TO_W bits");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             live;
  logic             busy_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             err_q;
  logic             accept;
  logic             zero_op;
  logic             timeout;

  // live is low while rst is held so in_ready stays low through reset
  always_ff @(posedge clk) begin
    live <= ~rst;
  end

  assign accept  = (state == IDLE) && live && in_valid;
  assign zero_op = (in_a == '0) || (in_b == '0);

`ifdef GCD_DRV_WATCHDOG_EN
  logic [TO_W-1:0] wd_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if (state == LAUNCH) begin
      wd_cnt <= '0;
    end else if ((state == WAIT) && !eng_done) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // a result arriving on the limit cycle takes priority over the abort
  assign timeout = (state == WAIT) && !eng_done && (wd_cnt == TO_W'(TIMEOUT_CYCLES));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = zero_op ? RESP : LAUNCH;
      LAUNCH:  state_nxt = WAIT;
      WAIT:    if (eng_done || timeout) state_nxt = RESP;
      RESP:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) && live;
    out_valid = (state == RESP);
    eng_start = (state == LAUNCH);
    eng_rst   = timeout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= (state_nxt != IDLE);
    end
  end

  // operands move only on acceptance so the engine sees them stable for the whole job
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (accept) begin
        a_q <= in_a;
        b_q <= in_b;
        if (zero_op) begin
          res_q <= in_a | in_b;
          err_q <= 1'b0;
        end
      end
      if (state == WAIT) begin
        if (eng_done) begin
          res_q <= eng_result;
          err_q <= 1'b0;
        end else if (timeout) begin
          res_q <= '0;
          err_q <= 1'b1;
        end
      end
    end
  end

  assign eng_a   = a_q;
  assign eng_b   = b_q;
  assign out_gcd = res_q;
  assign out_err = err_q;
  assign busy    = busy_q;

endmodule
